sram_be_init: RTL and testbench
===============================

Name: sram_be_init

Overview:
Parametrised single-port-write / single-port-read buffer SRAM, successor to the basic router buffer. It adds:
- explicit DEPTH
- byte-enable writes
- configurable read latency (1 or 2)
- a selectable same-address read/write collision policy
- a hardware zero-initialisation FSM, run after reset or on demand

It sits in the sequential router as the activation/weight staging buffer.

Parameters:
ADDR_WIDTH, 8, address bits; DEPTH must be <= 2**ADDR_WIDTH
DEPTH, 256, number of words
DATA_WIDTH, 64, word width; must be a multiple of 8
READ_LATENCY, 1, cycles from accepted read to o_data_out_valid; legal values 1 or 2
WRITE_FIRST, 1, 1 = same-address read returns new write data; 0 = read returns old data

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  synchronous, active-high reset
i_write_en  input  1  write request
i_write_addr  input  ADDR_WIDTH  write address
i_data_in  input  DATA_WIDTH  write data
i_byte_en  input  DATA_WIDTH/8  per-byte write mask; bit k covers bits [8k+7:8k]
i_read_en  input  1  read request
i_read_addr  input  ADDR_WIDTH  read address
i_clear  input  1  pulse; starts re-initialisation
o_data_out  output  DATA_WIDTH  read data
o_data_out_valid  output  1  o_data_out valid this cycle
o_ready  output  1  1 = requests accepted
o_addr_err  output  1  one-cycle pulse on an out-of-range access

Behaviour:
- One clock domain; reset is synchronous and active-high, sampled on the rising edge of i_clk.
- Reset values: o_data_out=0, o_data_out_valid=0, o_ready=0, o_addr_err=0, FSM=INIT, init counter=0. All read-pipeline valid bits are cleared.
- FSM has two states, INIT and READY.
- INIT:
  - Each cycle writes all-zero to address init counter, then increments the counter.
  - When the counter reaches DEPTH-1 and that word is written, the next state is READY.
  - INIT lasts exactly DEPTH cycles; o_ready=0 throughout.
  - i_write_en, i_read_en and i_clear are ignored, with no valid and no error.
- READY:
  - o_ready=1.
  - i_clear=1 -> INIT next cycle, counter=0. Any request in the same cycle is ignored.
  - A read already in flight still completes, with the data sampled at acceptance.
- Write (READY, i_write_en=1, addr<DEPTH): for each byte k with i_byte_en[k]=1, mem[addr] byte k <= i_data_in byte k. Other bytes are unchanged. i_byte_en=0 writes nothing and is not an error.
- Read (READY, i_read_en=1, addr<DEPTH):
  - The data is sampled at the accepting edge.
  - READ_LATENCY=1: o_data_out/o_data_out_valid update at that edge, i.e. visible the cycle after the request.
  - READ_LATENCY=2: a further output register is added (one more cycle).
  - Back-to-back reads give one result per cycle, in order.
  - When no read completes, o_data_out_valid=0 and o_data_out holds its last value.
- Collision (READY, both enables, same address):
  - WRITE_FIRST=1: read returns the merge of old word and new bytes per i_byte_en.
  - WRITE_FIRST=0: read returns the pre-write word.
  - The write is always performed.
- Out of range (addr >= DEPTH; only when DEPTH < 2**ADDR_WIDTH):
  - Write is dropped.
  - Read completes with o_data_out=0 and o_data_out_valid=1 after READ_LATENCY.
  - o_addr_err pulses the cycle after the request (either port; OR of both).
- Reset mid-operation (i_rst during INIT or READY): all state returns to reset values next cycle, in-flight reads are discarded, and INIT restarts from address 0. Memory contents are not reset directly; the INIT sweep zeroes them.

Decomposition:
- Package sram_pkg:
  - state enum sram_state_e {SRAM_INIT, SRAM_READY}
  - localparam BYTES = DATA_WIDTH/8
  - function byte_merge(old, new, be) returning the masked word, shared by the write path and WRITE_FIRST bypass
- Sub-module sram_init_ctrl: FSM plus $clog2(DEPTH)-bit counter. It outputs o_ready, init_we and init_addr to the parent, which muxes the init write over the user write.
- Memory array, read pipeline and collision bypass stay in the parent.

Test Plan:
- Reset, then DEPTH=16 -> o_ready low for exactly 16 cycles; read of every address 0..15 returns 0x0 with valid one cycle later (LAT=1).
- Write addr 3 = 0x1122334455667788 with be=0xFF, then be=0x0F with data 0xAAAAAAAAAAAAAAAA, then read addr 3 -> 0x11223344AAAAAAAA.
- Simultaneous write addr 5 = 0xDEAD (be=0x03) and read addr 5 -> WRITE_FIRST=1 returns 0x000000000000DEAD; WRITE_FIRST=0 returns 0x0.
- READ_LATENCY=2, reads to addresses 1,2,3 on consecutive cycles (pre-written 0x10,0x20,0x30) -> valid on cycles +2,+3,+4 with data 0x10,0x20,0x30.
- DEPTH=12, ADDR_WIDTH=4: write addr 13, then read addr 13 -> o_addr_err pulses each time; read returns 0 with valid; addresses 0..11 are unchanged.
- After writes in READY, pulse i_clear with a read in flight -> the in-flight read returns old data; o_ready low for DEPTH cycles; all words read 0 afterwards. Repeat with i_rst asserted mid-INIT -> INIT restarts, full DEPTH cycles.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the byte-enable buffer SRAM with hardware zero-init.
package sram_pkg;

  typedef enum logic {
    SRAM_INIT  = 1'b0,
    SRAM_READY = 1'b1
  } sram_state_e;

  localparam int unsigned SRAM_DEFAULT_DW = 64;
  localparam int unsigned BYTES           = SRAM_DEFAULT_DW / 8;
  localparam int unsigned SRAM_MAX_DW     = 1024;
  localparam int unsigned SRAM_MAX_BYTES  = SRAM_MAX_DW / 8;

  // Replace each byte of old_word whose enable bit is set with the byte from new_word.
  function automatic logic [SRAM_MAX_DW-1:0] byte_merge(
    input logic [SRAM_MAX_DW-1:0]    old_word,
    input logic [SRAM_MAX_DW-1:0]    new_word,
    input logic [SRAM_MAX_BYTES-1:0] be
  );
    logic [SRAM_MAX_DW-1:0] res;
    res = old_word;
    for (int k = 0; k < int'(SRAM_MAX_BYTES); k++) begin
      if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_init_ctrl.sv
// Init/ready FSM: sweeps a zero write across every word after reset or a clear request.
module sram_init_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  output logic          o_ready,
  output logic          o_init_we,
  output logic [CW-1:0] o_init_addr
);

  sram_state_e r_state;
  sram_state_e w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= SRAM_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      SRAM_INIT: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(DEPTH - 1)) begin
          w_state_nxt = SRAM_READY;
          w_cnt_nxt   = '0;
        end
      end
      SRAM_READY: begin
        if (i_clear) begin
          w_state_nxt = SRAM_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = SRAM_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_ready     = (r_state == SRAM_READY);
  assign o_init_we   = (r_state == SRAM_INIT);
  assign o_init_addr = r_cnt;

endmodule

// File: rtl/sram_be_init.sv
// Staging-buffer SRAM: byte-enable writes, 1/2-cycle reads, collision policy, zero-init sweep.
module sram_be_init
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned WRITE_FIRST  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_write_en,
  input  logic [ADDR_WIDTH-1:0]   i_write_addr,
  input  logic [DATA_WIDTH-1:0]   i_data_in,
  input  logic [DATA_WIDTH/8-1:0] i_byte_en,
  input  logic                    i_read_en,
  input  logic [ADDR_WIDTH-1:0]   i_read_addr,
  input  logic                    i_clear,
  output logic [DATA_WIDTH-1:0]   o_data_out,
  output logic                    o_data_out_valid,
  output logic                    o_ready,
  output logic                    o_addr_err
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic          w_ready;
  logic          w_init_we;
  logic [IW-1:0] w_init_addr;

  sram_init_ctrl #(
    .DEPTH (DEPTH),
    .CW    (IW)
  ) u_init_ctrl (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_clear),
    .o_ready     (w_ready),
    .o_init_we   (w_init_we),
    .o_init_addr (w_init_addr)
  );

  logic                  w_wr_inr;
  logic                  w_rd_inr;
  logic [IW-1:0]         w_widx;
  logic [IW-1:0]         w_ridx;
  logic                  w_accept;
  logic                  w_user_we;
  logic                  w_rd_acc;
  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_wr_old;
  logic [DATA_WIDTH-1:0] w_wr_merged;
  logic [DATA_WIDTH-1:0] w_rd_raw;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_mem_we;
  logic [IW-1:0]         w_mem_idx;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_err_nxt;

  assign w_wr_inr  = (32'(i_write_addr) < DEPTH);
  assign w_rd_inr  = (32'(i_read_addr) < DEPTH);
  assign w_widx    = IW'(i_write_addr);
  assign w_ridx    = IW'(i_read_addr);

  // A clear in READY swallows any request presented alongside it.
  assign w_accept  = w_ready & ~i_clear & ~i_rst;
  assign w_user_we = w_accept & i_write_en & w_wr_inr;
  assign w_rd_acc  = w_accept & i_read_en;
  assign w_err_nxt = w_accept & ((i_write_en & ~w_wr_inr) | (i_read_en & ~w_rd_inr));

  assign w_wr_old    = r_mem[w_widx];
  assign w_wr_merged = DATA_WIDTH'(byte_merge(SRAM_MAX_DW'(w_wr_old), SRAM_MAX_DW'(i_data_in),
                                              SRAM_MAX_BYTES'(i_byte_en)));

  assign w_rd_raw  = w_rd_inr ? r_mem[w_ridx] : '0;
  assign w_collide = (WRITE_FIRST != 0) && w_user_we && (i_write_addr == i_read_addr);
  assign w_rd_data = w_collide ? w_wr_merged : w_rd_raw;

  assign w_mem_we    = ~i_rst & (w_init_we | w_user_we);
  assign w_mem_idx   = w_init_we ? w_init_addr : w_widx;
  assign w_mem_wdata = w_init_we ? '0 : w_wr_merged;

  // Storage array carries no reset; the init sweep zeroes it.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
  end

  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic                  r_addr_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_acc;
      if (w_rd_acc) r_s1_data <= w_rd_data;
      r_addr_err <= w_err_nxt;
    end
  end

  generate
    if (READ_LATENCY >= 2) begin : g_lat2
      logic                  r_s2_valid;
      logic [DATA_WIDTH-1:0] r_s2_data;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) r_s2_data <= r_s1_data;
        end
      end

      assign o_data_out       = r_s2_data;
      assign o_data_out_valid = r_s2_valid;
    end else begin : g_lat1
      assign o_data_out       = r_s1_data;
      assign o_data_out_valid = r_s1_valid;
    end
  endgenerate

  assign o_ready    = w_ready;
  assign o_addr_err = r_addr_err;

endmodule

// File: tb/tb_sram_be_init.sv
// Bench: two configurations of sram_be_init driven in lockstep against a behavioural model.
module tb_sram_be_init;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned NB = 8;
  localparam int A_DEPTH = 12;
  localparam int B_DEPTH = 16;
  localparam int A_LAT   = 1;
  localparam int B_LAT   = 2;
  localparam int A_WF    = 1;
  localparam int B_WF    = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          we;
  logic          re;
  logic          clr;
  logic [AW-1:0] wa;
  logic [AW-1:0] ra;
  logic [DW-1:0] din;
  logic [NB-1:0] be;

  logic [DW-1:0] d_out [2];
  logic          v_out [2];
  logic          rdy   [2];
  logic          err   [2];

  sram_be_init #(
    .ADDR_WIDTH(AW), .DEPTH(A_DEPTH), .DATA_WIDTH(DW), .READ_LATENCY(A_LAT), .WRITE_FIRST(A_WF)
  ) u_a (
    .i_clk(clk), .i_rst(rst), .i_write_en(we), .i_write_addr(wa), .i_data_in(din),
    .i_byte_en(be), .i_read_en(re), .i_read_addr(ra), .i_clear(clr),
    .o_data_out(d_out[0]), .o_data_out_valid(v_out[0]), .o_ready(rdy[0]), .o_addr_err(err[0])
  );

  sram_be_init #(
    .ADDR_WIDTH(AW), .DEPTH(B_DEPTH), .DATA_WIDTH(DW), .READ_LATENCY(B_LAT), .WRITE_FIRST(B_WF)
  ) u_b (
    .i_clk(clk), .i_rst(rst), .i_write_en(we), .i_write_addr(wa), .i_data_in(din),
    .i_byte_en(be), .i_read_en(re), .i_read_addr(ra), .i_clear(clr),
    .o_data_out(d_out[1]), .o_data_out_valid(v_out[1]), .o_ready(rdy[1]), .o_addr_err(err[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Behavioural model: word array, init countdown, queue of reads tagged with the edge they surface.
  typedef struct {
    int          due;
    logic [63:0] d;
  } rd_t;

  rd_t         q0[$];
  rd_t         q1[$];
  logic [63:0] m_mem [2][16];
  int          m_left [2];
  logic [63:0] e_data [2];
  logic        e_valid [2];
  logic        e_err [2];
  logic        e_ready [2];
  bit          e_on = 1'b0;
  int          m_edge = 0;

  function automatic logic [63:0] merge_ref(input logic [63:0] o, input logic [63:0] n,
                                            input logic [7:0] b);
    logic [63:0] mask;
    mask = '0;
    for (int k = 0; k < 8; k++) if (b[k]) mask = mask | (64'hFF << (8 * k));
    return (o & ~mask) | (n & mask);
  endfunction

  task automatic model_step(input int i);
    int          dep;
    int          lat;
    bit          wf;
    bit          wok;
    bit          rok;
    logic [63:0] rd;
    rd_t         r;
    dep = (i == 0) ? A_DEPTH : B_DEPTH;
    lat = (i == 0) ? A_LAT : B_LAT;
    wf  = (i == 0) ? (A_WF != 0) : (B_WF != 0);
    if (rst) begin
      m_left[i] = dep;
      if (i == 0) q0.delete(); else q1.delete();
      e_data[i] = '0; e_valid[i] = 1'b0; e_err[i] = 1'b0; e_ready[i] = 1'b0;
      return;
    end
    e_valid[i] = 1'b0;
    e_err[i]   = 1'b0;
    if (m_left[i] > 0) begin
      m_mem[i][dep - m_left[i]] = '0;
      m_left[i]--;
    end else if (clr) begin
      m_left[i] = dep;
    end else begin
      wok = int'(wa) < dep;
      rok = int'(ra) < dep;
      if (re) begin
        rd = rok ? m_mem[i][ra] : 64'h0;
        if (wf && we && wok && wa == ra) rd = merge_ref(rd, din, be);
        r.due = m_edge + lat - 1;
        r.d   = rd;
        if (i == 0) q0.push_back(r); else q1.push_back(r);
      end
      if (we && wok) m_mem[i][wa] = merge_ref(m_mem[i][wa], din, be);
      e_err[i] = (we && !wok) || (re && !rok);
    end
    if (i == 0) begin
      if (q0.size() > 0 && q0[0].due == m_edge) begin
        e_valid[i] = 1'b1; e_data[i] = q0[0].d; void'(q0.pop_front());
      end
    end else begin
      if (q1.size() > 0 && q1[0].due == m_edge) begin
        e_valid[i] = 1'b1; e_data[i] = q1[0].d; void'(q1.pop_front());
      end
    end
    e_ready[i] = (m_left[i] == 0);
  endtask

  always @(posedge clk) begin
    m_edge++;
    model_step(0);
    model_step(1);
    if (rst) e_on = 1'b1;
  end

  always @(negedge clk) begin
    if (e_on) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d ready", i), 64'(rdy[i]), 64'(e_ready[i]));
        check($sformatf("u%0d addr_err", i), 64'(err[i]), 64'(e_err[i]));
        check($sformatf("u%0d valid", i), 64'(v_out[i]), 64'(e_valid[i]));
        check($sformatf("u%0d data", i), d_out[i], e_data[i]);
      end
    end
  end

  task automatic cyc(input bit w, input logic [3:0] a_w, input logic [63:0] d, input logic [7:0] b,
                     input bit r, input logic [3:0] a_r, input bit c);
    we = w; wa = a_w; din = d; be = b; re = r; ra = a_r; clr = c;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 4'h0, 64'h0, 8'h00, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic rand_cyc(input bit allow_clear);
    cyc(1'($urandom_range(1)), 4'($urandom_range(15)), {$urandom, $urandom},
        ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom_range(255)),
        1'($urandom_range(1)), 4'($urandom_range(15)),
        allow_clear && ($urandom_range(149) == 0));
  endtask

  // Count low-ready cycles per instance; random traffic while both are still initialising.
  task automatic count_init(input string tag, input bit rnd);
    int la;
    int lb;
    la = 0;
    lb = 0;
    for (int c = 0; c < 40; c++) begin
      if (!rdy[0]) la++;
      if (!rdy[1]) lb++;
      if (rnd && !rdy[0]) begin
        cyc(1'($urandom_range(1)), 4'($urandom_range(15)), {$urandom, $urandom},
            8'($urandom_range(255)), 1'($urandom_range(1)), 4'($urandom_range(15)),
            1'($urandom_range(1)));
      end else begin
        idle();
      end
    end
    check({tag, " A init cycles"}, 64'(la), 64'd12);
    check({tag, " B init cycles"}, 64'(lb), 64'd16);
  endtask

  task automatic sweep_reads();
    for (int a = 0; a < 16; a++) cyc(1'b0, 4'h0, 64'h0, 8'h00, 1'b1, 4'(a), 1'b0);
    idle();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    we = 1'b0; re = 1'b0; clr = 1'b0; wa = '0; ra = '0; din = '0; be = '0;
    @(negedge clk);
    check("reset A ready", 64'(rdy[0]), 64'd0);
    check("reset A valid", 64'(v_out[0]), 64'd0);
    check("reset A data", d_out[0], 64'h0);
    check("reset B err", 64'(err[1]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    count_init("boot", 1'b1);
    sweep_reads();

    // Byte-enable partial overwrite
    cyc(1'b1, 4'd3, 64'h1122334455667788, 8'hFF, 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 4'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 64'h0, 8'h00, 1'b1, 4'd3, 1'b0);
    check("A be merge", d_out[0], 64'h11223344AAAAAAAA);
    check("A be merge valid", 64'(v_out[0]), 64'd1);
    idle();
    check("B be merge lat2", d_out[1], 64'h11223344AAAAAAAA);
    check("B be merge valid", 64'(v_out[1]), 64'd1);

    // Same-address collision: write-first vs read-first
    cyc(1'b1, 4'd5, 64'h000000000000DEAD, 8'h03, 1'b1, 4'd5, 1'b0);
    check("A collide write-first", d_out[0], 64'h000000000000DEAD);
    check("model A collide", e_data[0], 64'h000000000000DEAD);
    idle();
    check("B collide read-first", d_out[1], 64'h0);
    check("B collide valid", 64'(v_out[1]), 64'd1);

    // Back-to-back reads, two-cycle latency on B
    cyc(1'b1, 4'd1, 64'h10, 8'hFF, 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 4'd2, 64'h20, 8'hFF, 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 4'd3, 64'h30, 8'hFF, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 64'h0, 8'h00, 1'b1, 4'd1, 1'b0);
    check("A rd1", d_out[0], 64'h10);
    check("B none yet", 64'(v_out[1]), 64'd0);
    cyc(1'b0, 4'd0, 64'h0, 8'h00, 1'b1, 4'd2, 1'b0);
    check("B rd1", d_out[1], 64'h10);
    cyc(1'b0, 4'd0, 64'h0, 8'h00, 1'b1, 4'd3, 1'b0);
    check("B rd2", d_out[1], 64'h20);
    idle();
    check("B rd3", d_out[1], 64'h30);
    check("A idle valid", 64'(v_out[0]), 64'd0);
    check("A hold data", d_out[0], 64'h30);
    idle();
    check("B idle valid", 64'(v_out[1]), 64'd0);
    check("B hold data", d_out[1], 64'h30);

    // Out-of-range on A (DEPTH 12), in range on B
    cyc(1'b1, 4'd13, 64'hCAFE, 8'hFF, 1'b0, 4'd0, 1'b0);
    check("A oor write err", 64'(err[0]), 64'd1);
    check("B inr write err", 64'(err[1]), 64'd0);
    cyc(1'b0, 4'd0, 64'h0, 8'h00, 1'b1, 4'd13, 1'b0);
    check("A oor read err", 64'(err[0]), 64'd1);
    check("A oor read valid", 64'(v_out[0]), 64'd1);
    check("A oor read data", d_out[0], 64'h0);
    idle();
    check("A err cleared", 64'(err[0]), 64'd0);
    check("B addr13 data", d_out[1], 64'hCAFE);
    sweep_reads();

    // Clear with a read in flight
    cyc(1'b0, 4'd0, 64'h0, 8'h00, 1'b1, 4'd3, 1'b0);
    cyc(1'b1, 4'd3, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1, 4'd4, 1'b1);
    check("B inflight across clear", d_out[1], 64'h30);
    check("B inflight valid", 64'(v_out[1]), 64'd1);
    check("A ready after clear", 64'(rdy[0]), 64'd0);
    count_init("clear", 1'b1);
    cyc(1'b0, 4'd0, 64'h0, 8'h00, 1'b1, 4'd3, 1'b0);
    check("A zero after clear", d_out[0], 64'h0);
    sweep_reads();

    // Reset asserted mid-INIT restarts the sweep
    cyc(1'b0, 4'd0, 64'h0, 8'h00, 1'b1, 4'd3, 1'b1);
    for (int k = 0; k < 4; k++) idle();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("A valid after rst", 64'(v_out[0]), 64'd0);
    check("B valid after rst", 64'(v_out[1]), 64'd0);
    count_init("rst", 1'b0);
    sweep_reads();

    // Randomised traffic with occasional clear and reset
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(399) == 0);
      rand_cyc(1'b1);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) idle();
    sweep_reads();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
